// File: rtl/keypad_lock_ctrl_pkg.sv
// Shared types and constants for the keypad combination-lock controller:
// key codes, decoded-key / state / buzzer-pattern enums, display glyphs.
package keypad_pkg;

    localparam logic [15:0] OH_D0     = 16'h0008;
    localparam logic [15:0] OH_D1     = 16'h0080;
    localparam logic [15:0] OH_D2     = 16'h0040;
    localparam logic [15:0] OH_D3     = 16'h0020;
    localparam logic [15:0] OH_D4     = 16'h0800;
    localparam logic [15:0] OH_D5     = 16'h0400;
    localparam logic [15:0] OH_D6     = 16'h0200;
    localparam logic [15:0] OH_D7     = 16'h8000;
    localparam logic [15:0] OH_D8     = 16'h4000;
    localparam logic [15:0] OH_D9     = 16'h2000;
    localparam logic [15:0] OH_ENTER  = 16'h0001;
    localparam logic [15:0] OH_CLEAR  = 16'h1000;
    localparam logic [15:0] OH_MASTER = 16'h0100;

    localparam logic [3:0] BLANK      = 4'hF;
    localparam logic [3:0] OPEN_GLYPH = 4'hA;

    // Digit keys carry their own BCD value so the datapath can use the enum directly.
    typedef enum logic [3:0] {
        K_D0 = 4'd0, K_D1 = 4'd1, K_D2 = 4'd2, K_D3 = 4'd3, K_D4 = 4'd4,
        K_D5 = 4'd5, K_D6 = 4'd6, K_D7 = 4'd7, K_D8 = 4'd8, K_D9 = 4'd9,
        K_ENTER = 4'd10, K_CLEAR = 4'd11, K_MASTER = 4'd12, K_NONE = 4'd15
    } key_e;

    typedef enum logic [1:0] {ST_ENTRY, ST_OPEN, ST_LOCKOUT} state_e;

    typedef enum logic [1:0] {PAT_KEY, PAT_OK, PAT_FAIL} pat_e;

    function automatic key_e decode_key(input logic [15:0] oh);
        case (oh)
            OH_D0:     return K_D0;
            OH_D1:     return K_D1;
            OH_D2:     return K_D2;
            OH_D3:     return K_D3;
            OH_D4:     return K_D4;
            OH_D5:     return K_D5;
            OH_D6:     return K_D6;
            OH_D7:     return K_D7;
            OH_D8:     return K_D8;
            OH_D9:     return K_D9;
            OH_ENTER:  return K_ENTER;
            OH_CLEAR:  return K_CLEAR;
            OH_MASTER: return K_MASTER;
            default:   return K_NONE;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] tens;
        logic [6:0] ones;
        tens = v / 7'd10;
        ones = v - tens * 7'd10;
        return {tens[3:0], ones[3:0]};
    endfunction

endpackage

// File: rtl/keypad_lock_ctrl_if.sv
// Keypad-side inputs and display/status outputs of the lock controller.
interface keypad_lock_ctrl_if #(
    parameter int DIGITS = 4
) ();
    localparam int TW = $clog2(DIGITS + 1);

    logic                  tick_1hz;
    logic [15:0]           onehot;
    logic [4*DIGITS-1:0]   binary;
    logic [TW-1:0]         times;
    logic [3:0]            tries;
    logic                  locked;
    logic                  unlocked;
    logic                  buzzer;

    modport master (
        output tick_1hz, onehot,
        input  binary, times, tries, locked, unlocked, buzzer
    );

    modport slave (
        input  tick_1hz, onehot,
        output binary, times, tries, locked, unlocked, buzzer
    );
endinterface

// File: rtl/keypad_lock_ctrl_buzzer.sv
// Buzzer pattern generator: a start pulse loads duration and half-period
// down-counters for the chosen pattern; the fail pattern mutes its middle third.
module buzzer_pattern_gen
    import keypad_pkg::*;
#(
    parameter int KEY_HALF  = 50000,
    parameter int OK_HALF   = 25000,
    parameter int FAIL_HALF = 100000,
    parameter int KEY_LEN   = 10000000,
    parameter int OK_LEN    = 30000000,
    parameter int FAIL_LEN  = 15000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  pat_e i_pat,
    output logic o_buzzer
);
    localparam int HALF_MAX = (KEY_HALF > OK_HALF) ?
                              ((KEY_HALF > FAIL_HALF) ? KEY_HALF : FAIL_HALF) :
                              ((OK_HALF > FAIL_HALF) ? OK_HALF : FAIL_HALF);
    localparam int LEN_MAX  = (KEY_LEN > OK_LEN) ?
                              ((KEY_LEN > FAIL_LEN) ? KEY_LEN : FAIL_LEN) :
                              ((OK_LEN > FAIL_LEN) ? OK_LEN : FAIL_LEN);
    localparam int HW = $clog2(HALF_MAX);
    localparam int DW = $clog2(LEN_MAX);

    localparam logic [HW-1:0] KEY_HALF_M1  = HW'(KEY_HALF - 1);
    localparam logic [HW-1:0] OK_HALF_M1   = HW'(OK_HALF - 1);
    localparam logic [HW-1:0] FAIL_HALF_M1 = HW'(FAIL_HALF - 1);
    localparam logic [DW-1:0] KEY_LEN_M1   = DW'(KEY_LEN - 1);
    localparam logic [DW-1:0] OK_LEN_M1    = DW'(OK_LEN - 1);
    localparam logic [DW-1:0] FAIL_LEN_M1  = DW'(FAIL_LEN - 1);
    // Remaining-count window equivalent to elapsed cycles [LEN/3, 2*(LEN/3)).
    localparam logic [DW-1:0] MUTE_HI = DW'(FAIL_LEN - 1 - FAIL_LEN / 3);
    localparam logic [DW-1:0] MUTE_LO = DW'(FAIL_LEN - 2 * (FAIL_LEN / 3));

    logic          r_active;
    logic          r_tone;
    logic [DW-1:0] r_dur;
    logic [HW-1:0] r_half;
    pat_e          r_pat;

    logic [DW-1:0] w_load_dur;
    logic [HW-1:0] w_load_half;
    logic [HW-1:0] w_reload_half;
    logic          w_mute;

    always_comb begin
        w_load_dur    = KEY_LEN_M1;
        w_load_half   = KEY_HALF_M1;
        w_reload_half = KEY_HALF_M1;
        case (i_pat)
            PAT_OK:   begin w_load_dur = OK_LEN_M1;   w_load_half = OK_HALF_M1;   end
            PAT_FAIL: begin w_load_dur = FAIL_LEN_M1; w_load_half = FAIL_HALF_M1; end
            default:  ;
        endcase
        case (r_pat)
            PAT_OK:   w_reload_half = OK_HALF_M1;
            PAT_FAIL: w_reload_half = FAIL_HALF_M1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_tone   <= 1'b0;
            r_dur    <= '0;
            r_half   <= '0;
            r_pat    <= PAT_KEY;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_tone   <= 1'b1;
            r_dur    <= w_load_dur;
            r_half   <= w_load_half;
            r_pat    <= i_pat;
        end else if (r_active) begin
            if (r_dur == '0) begin
                r_active <= 1'b0;
                r_tone   <= 1'b0;
            end else begin
                r_dur <= r_dur - DW'(1);
                if (r_half == '0) begin
                    r_tone <= ~r_tone;
                    r_half <= w_reload_half;
                end else begin
                    r_half <= r_half - HW'(1);
                end
            end
        end
    end

    assign w_mute   = (r_pat == PAT_FAIL) && (r_dur <= MUTE_HI) && (r_dur >= MUTE_LO);
    assign o_buzzer = r_tone & ~w_mute;

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad combination lock: digit entry, code compare, failed-try lockout with
// seconds countdown on the display, and buzzer pattern requests.
//   state      | meaning
//   ST_ENTRY   | collecting digits, ENTER compares against CODE
//   ST_OPEN    | code accepted, display shows OPEN_GLYPH, unlocked high
//   ST_LOCKOUT | too many failures, counting down seconds, only MASTER exits
module keypad_lock_ctrl
    import keypad_pkg::*;
#(
    parameter int                  DIGITS    = 4,
    parameter logic [4*DIGITS-1:0] CODE      = 16'h0246,
    parameter int                  MAX_TRIES = 6,
    parameter int                  LOCK_SECS = 60,
    parameter int                  KEY_HALF  = 50000,
    parameter int                  OK_HALF   = 25000,
    parameter int                  FAIL_HALF = 100000,
    parameter int                  KEY_LEN   = 10000000,
    parameter int                  OK_LEN    = 30000000,
    parameter int                  FAIL_LEN  = 15000000
) (
    input logic               clk,
    input logic               rst_n,
    keypad_lock_ctrl_if.slave bus
);
    localparam int TW = $clog2(DIGITS + 1);
    localparam int RW = $clog2(LOCK_SECS + 1);
    localparam logic [4*DIGITS-1:0] ALL_BLANK = {DIGITS{BLANK}};

    state_e              r_state, w_state_nxt;
    logic [4*DIGITS-1:0] r_entry, w_entry_nxt;
    logic [TW-1:0]       r_times, w_times_nxt;
    logic [3:0]          r_tries, w_tries_nxt;
    logic [RW-1:0]       r_remain, w_remain_nxt;
    key_e                r_prev_key;

    key_e                w_key;
    logic                w_press;
    logic [3:0]          w_digit;
    logic                w_is_digit;
    logic [3:0]          w_tries_inc;
    logic                w_req_key, w_req_ok, w_req_fail;
    logic                w_buzz_start;
    pat_e                w_buzz_pat;
    logic [4*DIGITS-1:0] w_lock_disp;

    always_comb begin
        w_key       = decode_key(bus.onehot);
        w_press     = (w_key != K_NONE) && (w_key != r_prev_key);
        w_digit     = 4'(w_key);
        w_is_digit  = (w_digit < 4'd10);
        w_tries_inc = (r_tries == 4'hF) ? 4'hF : r_tries + 4'd1;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_entry_nxt  = r_entry;
        w_times_nxt  = r_times;
        w_tries_nxt  = r_tries;
        w_remain_nxt = r_remain;
        w_req_key    = 1'b0;
        w_req_ok     = 1'b0;
        w_req_fail   = 1'b0;
        case (r_state)
            ST_ENTRY: begin
                if (w_press && w_is_digit) begin
                    if (r_times != TW'(DIGITS)) begin
                        w_entry_nxt = {r_entry[4*DIGITS-5:0], w_digit};
                        w_times_nxt = r_times + TW'(1);
                        w_req_key   = 1'b1;
                    end
                end else if (w_press) begin
                    case (w_key)
                        K_CLEAR, K_MASTER: begin
                            w_entry_nxt = ALL_BLANK;
                            w_times_nxt = '0;
                            w_req_key   = 1'b1;
                            if (w_key == K_MASTER) w_tries_nxt = '0;
                        end
                        K_ENTER: begin
                            if (r_times == TW'(DIGITS)) begin
                                if (r_entry == CODE) begin
                                    w_state_nxt = ST_OPEN;
                                    w_req_ok    = 1'b1;
                                end else begin
                                    w_entry_nxt = ALL_BLANK;
                                    w_times_nxt = '0;
                                    w_tries_nxt = w_tries_inc;
                                    w_req_fail  = 1'b1;
                                    if (w_tries_inc >= 4'(MAX_TRIES)) begin
                                        w_state_nxt  = ST_LOCKOUT;
                                        w_remain_nxt = RW'(LOCK_SECS);
                                    end
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_OPEN: begin
                if (w_press && (w_key == K_CLEAR || w_key == K_MASTER)) begin
                    w_state_nxt = ST_ENTRY;
                    w_entry_nxt = ALL_BLANK;
                    w_times_nxt = '0;
                    w_tries_nxt = '0;
                    w_req_key   = 1'b1;
                end
            end
            ST_LOCKOUT: begin
                // MASTER takes precedence over a coincident second tick.
                if (w_press && w_key == K_MASTER) begin
                    w_state_nxt = ST_ENTRY;
                    w_entry_nxt = ALL_BLANK;
                    w_times_nxt = '0;
                    w_tries_nxt = '0;
                end else if (bus.tick_1hz) begin
                    if (r_remain <= RW'(1)) begin
                        w_state_nxt  = ST_ENTRY;
                        w_entry_nxt  = ALL_BLANK;
                        w_tries_nxt  = '0;
                        w_remain_nxt = '0;
                    end else begin
                        w_remain_nxt = r_remain - RW'(1);
                    end
                end
            end
            default: w_state_nxt = ST_ENTRY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_ENTRY;
            r_entry    <= ALL_BLANK;
            r_times    <= '0;
            r_tries    <= '0;
            r_remain   <= '0;
            r_prev_key <= K_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_entry    <= w_entry_nxt;
            r_times    <= w_times_nxt;
            r_tries    <= w_tries_nxt;
            r_remain   <= w_remain_nxt;
            r_prev_key <= w_key;
        end
    end

    assign w_buzz_start = w_req_fail | w_req_ok | w_req_key;
    assign w_buzz_pat   = w_req_fail ? PAT_FAIL : (w_req_ok ? PAT_OK : PAT_KEY);

    buzzer_pattern_gen #(
        .KEY_HALF  (KEY_HALF),
        .OK_HALF   (OK_HALF),
        .FAIL_HALF (FAIL_HALF),
        .KEY_LEN   (KEY_LEN),
        .OK_LEN    (OK_LEN),
        .FAIL_LEN  (FAIL_LEN)
    ) u_buzzer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_buzz_start),
        .i_pat    (w_buzz_pat),
        .o_buzzer (bus.buzzer)
    );

    always_comb begin
        w_lock_disp      = ALL_BLANK;
        w_lock_disp[7:0] = to_bcd(7'(r_remain));
    end

    assign bus.binary   = (r_state == ST_OPEN)    ? {DIGITS{OPEN_GLYPH}} :
                          (r_state == ST_LOCKOUT) ? w_lock_disp : r_entry;
    assign bus.times    = r_times;
    assign bus.tries    = r_tries;
    assign bus.locked   = (r_state == ST_LOCKOUT);
    assign bus.unlocked = (r_state == ST_OPEN);

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Bench for keypad_lock_ctrl with shortened tone/lockout parameters; directed
// scenarios plus random key/tick traffic against a queue-based lock model.
module tb_keypad_lock_ctrl;
    localparam int DIGITS    = 4;
    localparam int MAX_TRIES = 3;
    localparam int LOCK_SECS = 12;
    localparam int KEY_HALF  = 3;
    localparam int OK_HALF   = 2;
    localparam int FAIL_HALF = 4;
    localparam int KEY_LEN   = 20;
    localparam int OK_LEN    = 30;
    localparam int FAIL_LEN  = 36;

    localparam int KENTER = 10, KCLEAR = 11, KMASTER = 12, KBAD1 = 13, KBAD2 = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    int   m_mode;
    int   m_dig[$];
    int   m_tries;
    int   m_remain;

    keypad_lock_ctrl_if #(.DIGITS(DIGITS)) bus ();

    keypad_lock_ctrl #(
        .DIGITS(DIGITS), .CODE(16'h0246), .MAX_TRIES(MAX_TRIES), .LOCK_SECS(LOCK_SECS),
        .KEY_HALF(KEY_HALF), .OK_HALF(OK_HALF), .FAIL_HALF(FAIL_HALF),
        .KEY_LEN(KEY_LEN), .OK_LEN(OK_LEN), .FAIL_LEN(FAIL_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] key_oh(input int k);
        case (k)
            0: return 16'h0008;  1: return 16'h0080;  2: return 16'h0040;
            3: return 16'h0020;  4: return 16'h0800;  5: return 16'h0400;
            6: return 16'h0200;  7: return 16'h8000;  8: return 16'h4000;
            9: return 16'h2000;  KENTER: return 16'h0001;
            KCLEAR: return 16'h1000;  KMASTER: return 16'h0100;
            KBAD1: return 16'h0009;
            default: return 16'h0002;
        endcase
    endfunction

    function automatic logic exp_tone(input int e, input int half, input int len, input bit mute);
        if (e >= len) return 1'b0;
        if (mute && e >= len / 3 && e < 2 * (len / 3)) return 1'b0;
        return ((e / half) % 2) == 0;
    endfunction

    function automatic logic [15:0] exp_bin();
        logic [15:0] b;
        b = 16'hFFFF;
        if (m_mode == 1) return 16'hAAAA;
        if (m_mode == 2) return {8'hFF, 4'(m_remain / 10), 4'(m_remain % 10)};
        for (int i = 0; i < m_dig.size(); i++) b[4*i +: 4] = 4'(m_dig[m_dig.size() - 1 - i]);
        return b;
    endfunction

    task automatic model_key(input int k);
        int v;
        if (k > KMASTER) return;
        case (m_mode)
            0: begin
                if (k < 10) begin
                    if (m_dig.size() < DIGITS) m_dig.push_back(k);
                end else if (k == KCLEAR) begin
                    m_dig.delete();
                end else if (k == KMASTER) begin
                    m_dig.delete();
                    m_tries = 0;
                end else if (m_dig.size() == DIGITS) begin
                    v = m_dig[0] * 4096 + m_dig[1] * 256 + m_dig[2] * 16 + m_dig[3];
                    if (v == 'h0246) begin
                        m_mode = 1;
                    end else begin
                        m_dig.delete();
                        if (m_tries < 15) m_tries++;
                        if (m_tries >= MAX_TRIES) begin
                            m_mode = 2;
                            m_remain = LOCK_SECS;
                        end
                    end
                end
            end
            1: if (k == KCLEAR || k == KMASTER) begin
                m_mode = 0; m_dig.delete(); m_tries = 0;
            end
            default: if (k == KMASTER) begin
                m_mode = 0; m_dig.delete(); m_tries = 0;
            end
        endcase
    endtask

    task automatic model_tick();
        if (m_mode == 2) begin
            m_remain--;
            if (m_remain == 0) begin
                m_mode = 0; m_tries = 0; m_dig.delete();
            end
        end
    endtask

    task automatic press(input int k);
        @(negedge clk); bus.onehot = key_oh(k);
        @(negedge clk); bus.onehot = 16'h0;
    endtask

    task automatic tick();
        @(negedge clk); bus.tick_1hz = 1'b1;
        @(negedge clk); bus.tick_1hz = 1'b0;
    endtask

    task automatic wrong_code();
        press(9); press(9); press(9); press(9); press(KENTER);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.binary !== 16'hFFFF) begin bad++; $display("FAIL reset_binary got=%h want=ffff", bus.binary); end
        total++; if (bus.times !== 3'd0) begin bad++; $display("FAIL reset_times got=%0d want=0", bus.times); end
        total++; if (bus.tries !== 4'd0) begin bad++; $display("FAIL reset_tries got=%0d want=0", bus.tries); end
        total++; if (bus.locked !== 1'b0 || bus.unlocked !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", bus.locked, bus.unlocked); end
        total++; if (bus.buzzer !== 1'b0) begin bad++; $display("FAIL reset_buzzer got=%b want=0", bus.buzzer); end
    endtask

    task automatic test_success();
        int errs;
        errs = 0;
        press(0); press(2); press(4); press(6);
        total++; if (bus.binary !== 16'h0246 || bus.times !== 3'd4) begin bad++; $display("FAIL entry_0246 got=%h/%0d want=0246/4", bus.binary, bus.times); end
        press(KENTER);
        total++; if (bus.unlocked !== 1'b1 || bus.binary !== 16'hAAAA) begin bad++; $display("FAIL open got=%b/%h want=1/aaaa", bus.unlocked, bus.binary); end
        for (int e = 0; e < OK_LEN + 4; e++) begin
            if (bus.buzzer !== exp_tone(e, OK_HALF, OK_LEN, 1'b0)) errs++;
            @(negedge clk);
        end
        total++; if (errs != 0) begin bad++; $display("FAIL ok_tone wrong_cycles=%0d want=0", errs); end
        press(7);
        total++; if (bus.binary !== 16'hAAAA || bus.unlocked !== 1'b1) begin bad++; $display("FAIL open_ignores_digit got=%h want=aaaa", bus.binary); end
    endtask

    task automatic test_fail_tone();
        int errs;
        errs = 0;
        press(KCLEAR);
        total++; if (bus.unlocked !== 1'b0 || bus.binary !== 16'hFFFF) begin bad++; $display("FAIL open_clear got=%b/%h want=0/ffff", bus.unlocked, bus.binary); end
        press(1); press(2); press(3); press(4); press(KENTER);
        total++; if (bus.tries !== 4'd1 || bus.binary !== 16'hFFFF || bus.times !== 3'd0) begin bad++; $display("FAIL wrong_code got=%0d/%h/%0d want=1/ffff/0", bus.tries, bus.binary, bus.times); end
        for (int e = 0; e < FAIL_LEN + 4; e++) begin
            if (bus.buzzer !== exp_tone(e, FAIL_HALF, FAIL_LEN, 1'b1)) errs++;
            @(negedge clk);
        end
        total++; if (errs != 0) begin bad++; $display("FAIL fail_tone wrong_cycles=%0d want=0", errs); end
    endtask

    task automatic test_lockout();
        wrong_code();
        total++; if (bus.tries !== 4'd2 || bus.locked !== 1'b0) begin bad++; $display("FAIL tries_2 got=%0d/%b want=2/0", bus.tries, bus.locked); end
        wrong_code();
        total++; if (bus.locked !== 1'b1 || bus.binary !== 16'hFF12 || bus.tries !== 4'd3) begin bad++; $display("FAIL lock_enter got=%b/%h/%0d want=1/ff12/3", bus.locked, bus.binary, bus.tries); end
        press(5);
        total++; if (bus.binary !== 16'hFF12 || bus.times !== 3'd0) begin bad++; $display("FAIL lock_ignore got=%h/%0d want=ff12/0", bus.binary, bus.times); end
        repeat (LOCK_SECS - 1) tick();
        total++; if (bus.locked !== 1'b1 || bus.binary !== 16'hFF01) begin bad++; $display("FAIL lock_last got=%b/%h want=1/ff01", bus.locked, bus.binary); end
        tick();
        total++; if (bus.locked !== 1'b0 || bus.tries !== 4'd0 || bus.binary !== 16'hFFFF) begin bad++; $display("FAIL lock_expire got=%b/%0d/%h want=0/0/ffff", bus.locked, bus.tries, bus.binary); end
    endtask

    task automatic test_hold_key();
        int errs;
        errs = 0;
        repeat (40) @(negedge clk);
        bus.onehot = key_oh(5);
        @(negedge clk);
        for (int e = 0; e < 1000; e++) begin
            if (bus.buzzer !== exp_tone(e, KEY_HALF, KEY_LEN, 1'b0)) errs++;
            @(negedge clk);
        end
        bus.onehot = 16'h0;
        @(negedge clk);
        total++; if (errs != 0) begin bad++; $display("FAIL hold_beep wrong_cycles=%0d want=0", errs); end
        total++; if (bus.times !== 3'd1 || bus.binary !== 16'hFFF5) begin bad++; $display("FAIL hold_once got=%0d/%h want=1/fff5", bus.times, bus.binary); end
        press(6); press(7); press(8);
        repeat (KEY_LEN + 5) @(negedge clk);
        errs = 0;
        press(9);
        for (int i = 0; i < 6; i++) begin
            if (bus.buzzer !== 1'b0) errs++;
            @(negedge clk);
        end
        total++; if (bus.times !== 3'd4 || bus.binary !== 16'h5678) begin bad++; $display("FAIL fifth_digit got=%0d/%h want=4/5678", bus.times, bus.binary); end
        total++; if (errs != 0) begin bad++; $display("FAIL fifth_no_beep beep_cycles=%0d want=0", errs); end
        press(KCLEAR);
    endtask

    task automatic test_master_tick();
        repeat (MAX_TRIES) wrong_code();
        tick(); tick();
        total++; if (bus.binary !== 16'hFF10 || bus.locked !== 1'b1) begin bad++; $display("FAIL lock_count got=%h want=ff10", bus.binary); end
        @(negedge clk);
        bus.onehot = key_oh(KMASTER);
        bus.tick_1hz = 1'b1;
        @(negedge clk);
        bus.onehot = 16'h0;
        bus.tick_1hz = 1'b0;
        total++; if (bus.locked !== 1'b0 || bus.tries !== 4'd0 || bus.times !== 3'd0 || bus.binary !== 16'hFFFF) begin
            bad++; $display("FAIL master_tick got=%b/%0d/%0d/%h want=0/0/0/ffff", bus.locked, bus.tries, bus.times, bus.binary);
        end
    endtask

    task automatic test_reset_mid_tone();
        int errs;
        errs = 0;
        wrong_code();
        press(0); press(2); press(4); press(6); press(KENTER);
        repeat (5) @(negedge clk);
        total++; if (bus.unlocked !== 1'b1 || bus.tries !== 4'd1) begin bad++; $display("FAIL pre_reset got=%b/%0d want=1/1", bus.unlocked, bus.tries); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (bus.buzzer !== 1'b0 || bus.unlocked !== 1'b0 || bus.binary !== 16'hFFFF || bus.tries !== 4'd0 || bus.times !== 3'd0 || bus.locked !== 1'b0) begin
            bad++; $display("FAIL mid_reset got=%b/%b/%h/%0d/%0d want=0/0/ffff/0/0", bus.buzzer, bus.unlocked, bus.binary, bus.tries, bus.times);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.buzzer !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL reset_silent beep_cycles=%0d want=0", errs); end
    endtask

    task automatic test_random();
        int r, k;
        int code_d[4];
        code_d[0] = 0; code_d[1] = 2; code_d[2] = 4; code_d[3] = 6;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_mode = 0; m_dig.delete(); m_tries = 0; m_remain = 0;
        for (int step = 0; step < 400; step++) begin
            r = $urandom_range(0, 99);
            if (r < ((m_mode == 2) ? 45 : 4)) begin
                tick();
                model_tick();
            end else begin
                r = $urandom_range(0, 99);
                if (r < 40)      k = code_d[m_dig.size() % 4];
                else if (r < 60) k = $urandom_range(0, 9);
                else if (r < 78) k = KENTER;
                else if (r < 84) k = KCLEAR;
                else if (r < 89) k = KMASTER;
                else if (r < 94) k = KBAD1;
                else             k = KBAD2;
                press(k);
                model_key(k);
            end
            total++; if (bus.binary !== exp_bin()) begin bad++; $display("FAIL rnd_binary step=%0d got=%h want=%h", step, bus.binary, exp_bin()); end
            total++; if (bus.times !== 3'(m_dig.size())) begin bad++; $display("FAIL rnd_times step=%0d got=%0d want=%0d", step, bus.times, m_dig.size()); end
            total++; if (bus.tries !== 4'(m_tries)) begin bad++; $display("FAIL rnd_tries step=%0d got=%0d want=%0d", step, bus.tries, m_tries); end
            total++; if (bus.locked !== (m_mode == 2)) begin bad++; $display("FAIL rnd_locked step=%0d got=%b want=%b", step, bus.locked, m_mode == 2); end
            total++; if (bus.unlocked !== (m_mode == 1)) begin bad++; $display("FAIL rnd_unlocked step=%0d got=%b want=%b", step, bus.unlocked, m_mode == 1); end
        end
    endtask

    initial begin
        bus.onehot   = 16'h0;
        bus.tick_1hz = 1'b0;
        test_reset();
        test_success();
        test_fail_tone();
        test_lockout();
        test_hold_key();
        test_master_tick();
        test_reset_mid_tone();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
